// File: rtl/fsrc_pkg.sv
// Shared helpers for the FSRC invalid-sample insert/remove datapaths.
package fsrc_pkg;

    localparam int MAX_NP    = 64;
    localparam int MAX_LANES = 256;

    // Invalid marker: only the sample MSB set. Callers truncate to their own NP.
    function automatic logic [MAX_NP-1:0] fsrc_invalid_sample(input int np);
        logic [MAX_NP-1:0] s;
        s = '0;
        s[np-1] = 1'b1;
        return s;
    endfunction

    function automatic int unsigned popcount(input logic [MAX_LANES-1:0] m);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (m[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/spread_holes.sv
// Expands a dense sample window into a word with invalid markers at the hole lanes,
// reporting how many window samples were used.
module spread_holes
    import fsrc_pkg::*;
#(
    parameter int WORD_LENGTH = 16,
    parameter int NUM_WORDS   = 32,
    localparam int CNT_W      = $clog2(NUM_WORDS + 1)
) (
    input  logic [NUM_WORDS-1:0]             holes_i,
    input  logic [NUM_WORDS*WORD_LENGTH-1:0] window_i,
    output logic [NUM_WORDS*WORD_LENGTH-1:0] word_o,
    output logic [CNT_W-1:0]                 consumed_o
);

    localparam logic [WORD_LENGTH-1:0] INVALID = WORD_LENGTH'(fsrc_invalid_sample(WORD_LENGTH));

    // k walks the dense window; it only advances on non-hole lanes.
    always_comb begin
        int k;
        k = 0;
        word_o = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (holes_i[i]) begin
                word_o[i*WORD_LENGTH +: WORD_LENGTH] = INVALID;
            end else begin
                word_o[i*WORD_LENGTH +: WORD_LENGTH] = window_i[k*WORD_LENGTH +: WORD_LENGTH];
                k++;
            end
        end
    end

    assign consumed_o = CNT_W'(NUM_WORDS - int'(popcount(MAX_LANES'(holes_i))));

endmodule

// File: rtl/tx_fsrc_insert_invalid.sv
// TX-side FSRC hole inserter: buffers dense input samples and emits fixed-rate words
// with invalid markers in the lanes requested by the converter.
module tx_fsrc_insert_invalid
    import fsrc_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int NP         = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fsrc_en,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     out_req,
    input  logic [DATA_WIDTH/NP-1:0] out_holes,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_valid,
    output logic                     underflow,
    input  logic                     underflow_clr
);

    localparam int NUM_SAMPLES = DATA_WIDTH / NP;
    localparam int CAP         = 2 * NUM_SAMPLES;
    localparam int BUF_W       = CAP * NP;
    localparam int CNT_W       = $clog2(CAP + 1);
    localparam int NEED_W      = $clog2(NUM_SAMPLES + 1);
    localparam logic [NP-1:0] INVALID = NP'(fsrc_invalid_sample(NP));

    // Sample FIFO packed with index 0 (oldest) in the low bits, so popping is a right shift.
    logic [BUF_W-1:0]       buf_q, buf_d, buf_shift, keep_mask, push_word;
    logic [CNT_W-1:0]       count_q, count_d, pop_n, push_n, base;
    logic                   ready_en_q;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d, spread_word;
    logic                   out_valid_q;
    logic                   underflow_q, underflow_d;
    logic [NUM_SAMPLES-1:0] holes_eff;
    logic [NEED_W-1:0]      need;
    logic                   do_pop, push;

    assign holes_eff = fsrc_en ? out_holes : '0;

    spread_holes #(
        .WORD_LENGTH(NP),
        .NUM_WORDS  (NUM_SAMPLES)
    ) u_spread (
        .holes_i   (holes_eff),
        .window_i  (buf_q[DATA_WIDTH-1:0]),
        .word_o    (spread_word),
        .consumed_o(need)
    );

    // ready_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready = ready_en_q && (count_q <= CNT_W'(NUM_SAMPLES));
    assign push     = in_valid && in_ready;
    assign do_pop   = out_req && (count_q >= CNT_W'(need));
    assign pop_n    = do_pop ? CNT_W'(need) : '0;
    assign push_n   = push ? CNT_W'(NUM_SAMPLES) : '0;
    assign count_d  = count_q - pop_n + push_n;
    assign base     = count_q - pop_n;

    // Stale bits above the live samples are masked before the new word is OR-ed in.
    always_comb begin
        buf_shift = buf_q >> (int'(pop_n) * NP);
        keep_mask = ~({BUF_W{1'b1}} << (int'(base) * NP));
        push_word = {{(BUF_W - DATA_WIDTH){1'b0}}, in_data};
        buf_d     = buf_shift;
        if (push) begin
            buf_d = (buf_shift & keep_mask) | (push_word << (int'(base) * NP));
        end
    end

    always_comb begin
        out_data_d  = do_pop ? spread_word : {NUM_SAMPLES{INVALID}};
        underflow_d = underflow_q;
        if (underflow_clr) underflow_d = 1'b0;
        if (out_req && !do_pop) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            ready_en_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            ready_en_q  <= 1'b1;
            out_valid_q <= out_req;
            underflow_q <= underflow_d;
            if (out_req) out_data_q <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_tx_fsrc_insert_invalid.sv
// Directed self-checking bench for tx_fsrc_insert_invalid at DATA_WIDTH=64, NP=16.
module tb_tx_fsrc_insert_invalid;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fsrc_en = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_req = 1'b0;
    logic [3:0]  out_holes = '0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        underflow;
    logic        underflow_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] W0     = 64'h0003_0002_0001_0000;
    localparam logic [63:0] W1     = 64'h0007_0006_0005_0004;
    localparam logic [63:0] W2     = 64'h000B_000A_0009_0008;
    localparam logic [63:0] W3     = 64'h000D_000C_000B_000A;
    localparam logic [63:0] ALLINV = 64'h8000_8000_8000_8000;

    tx_fsrc_insert_invalid #(.DATA_WIDTH(64), .NP(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .fsrc_en      (fsrc_en),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_req      (out_req),
        .out_holes    (out_holes),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .underflow    (underflow),
        .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        out_req = 1'b0;
        underflow_clr = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic push_word(input logic [63:0] w);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready: in_ready=%b expected 1", in_ready);
        end
        in_data = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || underflow !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b data=%h uf=%b rdy=%b expected 0 0 0 0",
                     out_valid, out_data, underflow, in_ready);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: in_ready=%b expected 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        fsrc_en = 1'b0;
        push_word(W0);
        push_word(W1);
        out_req = 1'b1;
        out_holes = 4'b1111;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== W0) begin
            errors++;
            $display("FAIL bypass_w0: valid=%b data=%h expected 1 %h", out_valid, out_data, W0);
        end
        tick();
        out_req = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== W1) begin
            errors++;
            $display("FAIL bypass_w1: valid=%b data=%h expected 1 %h", out_valid, out_data, W1);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL bypass_idle: valid=%b uf=%b expected 0 0", out_valid, underflow);
        end
    endtask

    task automatic test_insertion();
        do_reset();
        fsrc_en = 1'b1;
        push_word(W0);
        push_word(W1);
        out_req = 1'b1;
        out_holes = 4'b0100;
        tick();
        checks++;
        if (out_data !== 64'h0002_8000_0001_0000) begin
            errors++;
            $display("FAIL insert_0100: data=%h expected %h", out_data, 64'h0002_8000_0001_0000);
        end
        out_holes = 4'b0001;
        tick();
        checks++;
        if (out_data !== 64'h0005_0004_0003_8000) begin
            errors++;
            $display("FAIL insert_0001: data=%h expected %h", out_data, 64'h0005_0004_0003_8000);
        end
        out_holes = 4'b1100;
        tick();
        out_req = 1'b0;
        checks++;
        if (out_data !== 64'h8000_8000_0007_0006 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL insert_rest: data=%h uf=%b expected %h 0", out_data, underflow, 64'h8000_8000_0007_0006);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        fsrc_en = 1'b1;
        push_word(W0);
        push_word(W1);
        out_req = 1'b1;
        out_holes = 4'b0100;
        tick();
        out_req = 1'b0;
        in_data = W2;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_count5: in_ready=%b expected 0", in_ready);
        end
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_held: in_ready=%b expected 0", in_ready);
        end
        out_req = 1'b1;
        out_holes = 4'b0000;
        tick();
        out_req = 1'b0;
        checks++;
        if (out_data !== 64'h0006_0005_0004_0003 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_pop: data=%h rdy=%b expected %h 1", out_data, in_ready, 64'h0006_0005_0004_0003);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_pushed: in_ready=%b expected 0", in_ready);
        end
        out_req = 1'b1;
        tick();
        out_req = 1'b0;
        checks++;
        if (out_data !== 64'h000A_0009_0008_0007) begin
            errors++;
            $display("FAIL bp_order: data=%h expected %h", out_data, 64'h000A_0009_0008_0007);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        fsrc_en = 1'b1;
        out_req = 1'b1;
        out_holes = 4'b1111;
        tick();
        checks++;
        if (out_data !== ALLINV || underflow !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL need0: data=%h uf=%b valid=%b expected %h 0 1", out_data, underflow, out_valid, ALLINV);
        end
        out_req = 1'b0;
        push_word(W0);
        out_req = 1'b1;
        out_holes = 4'b1100;
        tick();
        checks++;
        if (out_data !== 64'h8000_8000_0001_0000) begin
            errors++;
            $display("FAIL uf_pre: data=%h expected %h", out_data, 64'h8000_8000_0001_0000);
        end
        out_holes = 4'b0000;
        tick();
        out_req = 1'b0;
        checks++;
        if (out_data !== ALLINV || underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_set: data=%h uf=%b expected %h 1", out_data, underflow, ALLINV);
        end
        tick();
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_sticky: uf=%b expected 1", underflow);
        end
        underflow_clr = 1'b1;
        tick();
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_clr: uf=%b expected 0", underflow);
        end
        out_req = 1'b1;
        out_holes = 4'b1100;
        tick();
        checks++;
        if (out_data !== 64'h8000_8000_0003_0002 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL uf_kept: data=%h uf=%b expected %h 0", out_data, underflow, 64'h8000_8000_0003_0002);
        end
        out_holes = 4'b0000;
        underflow_clr = 1'b1;
        tick();
        out_req = 1'b0;
        underflow_clr = 1'b0;
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL uf_set_wins: uf=%b expected 1", underflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fsrc_en = 1'b1;
        push_word(W0);
        in_data = W2;
        in_valid = 1'b1;
        out_req = 1'b1;
        out_holes = 4'b1000;
        tick();
        in_valid = 1'b0;
        out_req = 1'b0;
        checks++;
        if (out_data !== 64'h8000_0002_0001_0000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_out: data=%h rdy=%b expected %h 0", out_data, in_ready, 64'h8000_0002_0001_0000);
        end
        out_req = 1'b1;
        out_holes = 4'b0000;
        tick();
        checks++;
        if (out_data !== 64'h000A_0009_0008_0003) begin
            errors++;
            $display("FAIL b2b_order: data=%h expected %h", out_data, 64'h000A_0009_0008_0003);
        end
        fsrc_en = 1'b0;
        out_holes = 4'b1110;
        tick();
        out_req = 1'b0;
        checks++;
        if (out_data !== ALLINV || underflow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bypass_uf: data=%h uf=%b expected %h 1", out_data, underflow, ALLINV);
        end
        fsrc_en = 1'b1;
        out_req = 1'b1;
        tick();
        out_req = 1'b0;
        checks++;
        if (out_data !== 64'h8000_8000_8000_000B) begin
            errors++;
            $display("FAIL b2b_last: data=%h expected %h", out_data, 64'h8000_8000_8000_000B);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        fsrc_en = 1'b1;
        push_word(W0);
        push_word(W1);
        out_req = 1'b1;
        out_holes = 4'b0011;
        tick();
        out_req = 1'b0;
        checks++;
        if (out_data !== 64'h0001_0000_8000_8000 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: data=%h valid=%b expected %h 1", out_data, out_valid, 64'h0001_0000_8000_8000);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ar_immediate: valid=%b data=%h rdy=%b expected 0 0 0", out_valid, out_data, in_ready);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ar_ready: in_ready=%b expected 1", in_ready);
        end
        out_req = 1'b1;
        out_holes = 4'b1110;
        tick();
        out_req = 1'b0;
        checks++;
        if (out_data !== ALLINV || underflow !== 1'b1) begin
            errors++;
            $display("FAIL ar_empty: data=%h uf=%b expected %h 1", out_data, underflow, ALLINV);
        end
        push_word(W3);
        out_req = 1'b1;
        out_holes = 4'b0000;
        tick();
        out_req = 1'b0;
        checks++;
        if (out_data !== W3) begin
            errors++;
            $display("FAIL ar_fresh: data=%h expected %h", out_data, W3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bypass();
        test_insertion();
        test_backpressure();
        test_underflow();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
